// File: rtl/alu_pkg.sv
// Shared opcode/state types for multicycle_alu and its iterative datapath.
// Macro MULTICYCLE_ALU_DIV_EN decides whether DIVU/REMU count as iterative ops.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_AND   = 4'b0000,
        OP_OR    = 4'b0001,
        OP_ADD   = 4'b0010,
        OP_XOR   = 4'b0011,
        OP_SLLH  = 4'b0100,
        OP_SRL   = 4'b0101,
        OP_SUB   = 4'b0110,
        OP_SLTU  = 4'b0111,
        OP_EQZ   = 4'b1000,
        OP_ZEXTH = 4'b1001,
        OP_GRAY  = 4'b1010,
        OP_RSVD  = 4'b1011,
        OP_MUL   = 4'b1100,
        OP_MULHU = 4'b1101,
        OP_DIVU  = 4'b1110,
        OP_REMU  = 4'b1111
    } alu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } alu_state_t;

    function automatic logic is_iter_op(alu_op_t op);
`ifdef MULTICYCLE_ALU_DIV_EN
        return op[3:2] == 2'b11;
`else
        return (op == OP_MUL) || (op == OP_MULHU);
`endif
    endfunction

endpackage

// File: rtl/iter_muldiv.sv
// One-bit-per-cycle shift-add multiplier and (with MULTICYCLE_ALU_DIV_EN) restoring divider.
// Runs exactly WIDTH iterations after start; done flags the final iteration cycle.
module iter_muldiv #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sel_hi,
    input  logic             sel_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

    logic             running;
    logic [SHW-1:0]   cnt;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] opnd;
    logic             hi_sel;
    logic [WIDTH-1:0] hi_nxt;
    logic [WIDTH-1:0] lo_nxt;
    logic [WIDTH:0]   mul_sum;

`ifdef MULTICYCLE_ALU_DIV_EN
    logic             div_mode;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   rem_diff;
    logic             rem_ge;
`else
    logic             unused_sel_div;
    assign unused_sel_div = sel_div;
`endif

    // hi:lo is the product (multiplier shifts out of lo) or remainder:quotient
    always_comb begin
        mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
        hi_nxt  = mul_sum[WIDTH:1];
        lo_nxt  = {mul_sum[0], lo[WIDTH-1:1]};
`ifdef MULTICYCLE_ALU_DIV_EN
        rem_shift = {hi, lo[WIDTH-1]};
        rem_diff  = rem_shift - {1'b0, opnd};
        rem_ge    = rem_shift >= {1'b0, opnd};
        if (div_mode) begin
            hi_nxt = rem_ge ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
            lo_nxt = {lo[WIDTH-2:0], rem_ge};
        end
`endif
    end

    assign done   = running && (cnt == LAST);
    assign result = hi_sel ? hi_nxt : lo_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            running <= 1'b0;
            cnt     <= '0;
        end else if (start) begin
            running <= 1'b1;
            cnt     <= '0;
        end else if (running) begin
            running <= (cnt != LAST);
            cnt     <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (start) begin
            hi     <= '0;
            hi_sel <= sel_hi;
`ifdef MULTICYCLE_ALU_DIV_EN
            div_mode <= sel_div;
            lo       <= sel_div ? a : b;
            opnd     <= sel_div ? b : a;
`else
            lo       <= b;
            opnd     <= a;
`endif
        end else if (running) begin
            hi <= hi_nxt;
            lo <= lo_nxt;
        end
    end

endmodule

// File: rtl/multicycle_alu.sv
// Valid/ready ALU: single-cycle ops finish in 1 cycle, MUL/MULHU (and DIVU/REMU when
// MULTICYCLE_ALU_DIV_EN is defined) iterate for WIDTH cycles in iter_muldiv.
module multicycle_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       alucontrol,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             busy
);

    alu_state_t       state;
    alu_state_t       state_nxt;
    alu_op_t          op;
    logic             accept;
    logic             start;
    logic             iter_done;
    logic [WIDTH-1:0] iter_result;
    logic [WIDTH-1:0] single_result;

    assign op = alu_op_t'(alucontrol);

    function automatic logic [WIDTH-1:0] alu_single(alu_op_t f, logic [WIDTH-1:0] x,
                                                   logic [WIDTH-1:0] y);
        logic [WIDTH-1:0] r;
        r = '0;
        case (f)
            OP_AND:   r = x & y;
            OP_OR:    r = x | y;
            OP_ADD:   r = x + y;
            OP_XOR:   r = x ^ y;
            OP_SLLH:  r = y << (WIDTH / 2);
            OP_SRL:   r = y >> x[SHW-1:0];
            OP_SUB:   r = x - y;
            OP_SLTU:  r = {{(WIDTH-1){1'b0}}, (x < y)};
            OP_EQZ:   r = {{(WIDTH-1){1'b0}}, (x == '0)};
            OP_ZEXTH: r = {{(WIDTH/2){1'b0}}, y[WIDTH/2-1:0]};
            OP_GRAY:  r = x ^ (x >> 1);
            default:  r = '0;
        endcase
        return r;
    endfunction

    assign single_result = alu_single(op, a, b);

    always_comb begin
        state_nxt = state;
        in_ready  = !reset && ((state == ST_IDLE) || ((state == ST_DONE) && out_ready));
        accept    = in_valid && in_ready;
        start     = accept && is_iter_op(op);
        case (state)
            ST_IDLE: if (accept) state_nxt = start ? ST_BUSY : ST_DONE;
            ST_BUSY: if (iter_done) state_nxt = ST_DONE;
            ST_DONE: begin
                if (accept)         state_nxt = start ? ST_BUSY : ST_DONE;
                else if (out_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign busy      = (state == ST_BUSY);
    assign out_valid = (state == ST_DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // result/zero only change on a completion, so they hold under backpressure
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result <= '0;
            zero   <= 1'b0;
        end else if (accept && !start) begin
            result <= single_result;
            zero   <= (single_result == '0);
        end else if ((state == ST_BUSY) && iter_done) begin
            result <= iter_result;
            zero   <= (iter_result == '0);
        end
    end

    iter_muldiv #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_iter (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .sel_hi  (alucontrol[0]),
        .sel_div (alucontrol[1]),
        .a       (a),
        .b       (b),
        .done    (iter_done),
        .result  (iter_result)
    );

endmodule

// File: tb/tb_multicycle_alu.sv
// Directed self-checking bench for multicycle_alu (WIDTH=32 and WIDTH=8 instances).
module tb_multicycle_alu;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        in_valid, in_ready, out_valid, out_ready, zero, busy;
    logic [31:0] a, b, result;
    logic [3:0]  alucontrol;

    logic        in_valid8, in_ready8, out_valid8, zero8, busy8;
    logic [7:0]  a8, b8, result8;
    logic [3:0]  alucontrol8;

    int checks = 0;
    int errors = 0;
    int lat, bcnt;

    multicycle_alu dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .alucontrol(alucontrol), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .zero(zero), .busy(busy)
    );

    multicycle_alu #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .alucontrol(alucontrol8), .out_valid(out_valid8),
        .out_ready(1'b1), .result(result8), .zero(zero8), .busy(busy8)
    );

    // Present one op, wait for accept, scramble inputs, then count cycles to out_valid.
    task automatic issue(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
        int guard = 0;
        alucontrol = op; a = x; b = y; in_valid = 1'b1;
        while (!in_ready && guard < 50) begin @(posedge clk); #1; guard++; end
        @(posedge clk); #1;
        in_valid = 1'b0; a = ~x; b = ~y; alucontrol = 4'b0000;
        lat = 1; bcnt = 0;
        while (!out_valid && lat < 200) begin
            if (busy) bcnt++;
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic issue8(input logic [3:0] op, input logic [7:0] x, input logic [7:0] y);
        int guard = 0;
        alucontrol8 = op; a8 = x; b8 = y; in_valid8 = 1'b1;
        while (!in_ready8 && guard < 50) begin @(posedge clk); #1; guard++; end
        @(posedge clk); #1;
        in_valid8 = 1'b0; a8 = ~x; b8 = ~y;
        lat = 1;
        while (!out_valid8 && lat < 200) begin @(posedge clk); #1; lat++; end
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; a = '0; b = '0; alucontrol = '0; out_ready = 1'b1;
        in_valid8 = 1'b0; a8 = '0; b8 = '0; alucontrol8 = '0;
        #2;
        checks++; if ({out_valid, busy, in_ready, zero} !== 4'b0000) begin errors++;
            $display("FAIL reset_async_ctrl got %b want 0000", {out_valid, busy, in_ready, zero}); end
        @(posedge clk); #1; @(posedge clk); #1;
        checks++; if ({out_valid, busy, in_ready, zero} !== 4'b0000) begin errors++;
            $display("FAIL reset_ctrl got %b want 0000", {out_valid, busy, in_ready, zero}); end
        checks++; if (result !== 32'h0) begin errors++;
            $display("FAIL reset_result got %h want 00000000", result); end
        reset = 1'b0; #1;
        checks++; if (in_ready !== 1'b1) begin errors++;
            $display("FAIL reset_release_in_ready got %b want 1", in_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_sub();
        issue(4'b0110, 32'd5, 32'd7);
        checks++; if (result !== 32'hFFFF_FFFE) begin errors++;
            $display("FAIL sub_result got %h want fffffffe", result); end
        checks++; if (zero !== 1'b0) begin errors++;
            $display("FAIL sub_zero got %b want 0", zero); end
        checks++; if (lat != 1) begin errors++;
            $display("FAIL sub_latency got %0d want 1", lat); end
    endtask

    task automatic test_single();
        logic [3:0]  ops [17] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h6, 4'h7, 4'h7, 4'h2,
                                  4'h5, 4'h8, 4'h8, 4'h9, 4'hA, 4'hA, 4'hB, 4'h5};
        logic [31:0] xa [17] = '{32'h0FF0, 32'h0FF0, 32'h0FF0, 32'h0FF0, 32'h0FF0, 32'h0FF0,
                                 32'h0FF0, 32'h1, 32'hFFFF_FFFF, 32'd31, 32'h0, 32'h0FF0,
                                 32'h0, 32'h0FF0, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFE1};
        logic [31:0] xb [17] = '{32'h0F0F, 32'h0F0F, 32'h0F0F, 32'h0F0F, 32'h0F0F, 32'h0F0F,
                                 32'h0F0F, 32'h2, 32'h1, 32'h8000_0000, 32'h5, 32'h5,
                                 32'hABCD_1234, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'h8000_0000};
        logic [31:0] xr [17] = '{32'h0F00, 32'h0FFF, 32'h1EFF, 32'h00FF, 32'h0F0F_0000, 32'hE1,
                                 32'h0, 32'h1, 32'h0, 32'h1, 32'h1, 32'h0,
                                 32'h1234, 32'h0808, 32'hC000_0000, 32'h0, 32'h4000_0000};
        for (int i = 0; i < 17; i++) begin
            issue(ops[i], xa[i], xb[i]);
            checks++; if (result !== xr[i] || lat != 1) begin errors++;
                $display("FAIL single_%0d op %h got %h lat %0d want %h lat 1",
                         i, ops[i], result, lat, xr[i]); end
            checks++; if (zero !== (xr[i] == 32'h0)) begin errors++;
                $display("FAIL single_zero_%0d got %b want %b", i, zero, xr[i] == 32'h0); end
        end
    endtask

    task automatic test_mul();
        issue(4'b1100, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        checks++; if (result !== 32'h0000_0001) begin errors++;
            $display("FAIL mul_result got %h want 00000001", result); end
        checks++; if (lat != 33 || bcnt != 32) begin errors++;
            $display("FAIL mul_timing got lat %0d busy %0d want lat 33 busy 32", lat, bcnt); end
        issue(4'b1101, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        checks++; if (result !== 32'hFFFF_FFFE) begin errors++;
            $display("FAIL mulhu_result got %h want fffffffe", result); end
        checks++; if (lat != 33 || bcnt != 32) begin errors++;
            $display("FAIL mulhu_timing got lat %0d busy %0d want lat 33 busy 32", lat, bcnt); end
        issue(4'b1100, 32'h0001_0000, 32'h0003_0000);
        checks++; if (result !== 32'h0 || zero !== 1'b1) begin errors++;
            $display("FAIL mul_zero got %h/%b want 00000000/1", result, zero); end
        issue(4'b1101, 32'h0001_0000, 32'h0003_0000);
        checks++; if (result !== 32'h3 || zero !== 1'b0) begin errors++;
            $display("FAIL mulhu_small got %h/%b want 00000003/0", result, zero); end
    endtask

    task automatic test_div();
`ifdef MULTICYCLE_ALU_DIV_EN
        issue(4'b1110, 32'd100, 32'd7);
        checks++; if (result !== 32'd14 || lat != 33) begin errors++;
            $display("FAIL divu got %0d lat %0d want 14 lat 33", result, lat); end
        issue(4'b1111, 32'd100, 32'd7);
        checks++; if (result !== 32'd2 || lat != 33) begin errors++;
            $display("FAIL remu got %0d lat %0d want 2 lat 33", result, lat); end
        issue(4'b1110, 32'd100, 32'd0);
        checks++; if (result !== 32'hFFFF_FFFF) begin errors++;
            $display("FAIL divu_by0 got %h want ffffffff", result); end
        issue(4'b1111, 32'd100, 32'd0);
        checks++; if (result !== 32'd100 || zero !== 1'b0) begin errors++;
            $display("FAIL remu_by0 got %0d want 100", result); end
`else
        issue(4'b1110, 32'd100, 32'd7);
        checks++; if (result !== 32'd0 || zero !== 1'b1 || lat != 1) begin errors++;
            $display("FAIL divu_off got %h/%b lat %0d want 0/1 lat 1", result, zero, lat); end
        issue(4'b1111, 32'd100, 32'd7);
        checks++; if (result !== 32'd0 || zero !== 1'b1 || lat != 1) begin errors++;
            $display("FAIL remu_off got %h/%b lat %0d want 0/1 lat 1", result, zero, lat); end
`endif
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1; @(posedge clk); #1;
        out_ready = 1'b0;
        issue(4'b0010, 32'd3, 32'd4);
        checks++; if (result !== 32'd7 || lat != 1) begin errors++;
            $display("FAIL bp_first got %0d lat %0d want 7 lat 1", result, lat); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++; if (out_valid !== 1'b1 || result !== 32'd7 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold_%0d got v%b r%0d rdy%b want v1 r7 rdy0",
                         i, out_valid, result, in_ready); end
        end
        out_ready = 1'b1; alucontrol = 4'b0010; a = 32'd10; b = 32'd20; in_valid = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++;
            $display("FAIL b2b_in_ready got %b want 1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || result !== 32'd30) begin errors++;
            $display("FAIL b2b_result got v%b r%0d want v1 r30", out_valid, result); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++;
            $display("FAIL b2b_drain got %b want 0", out_valid); end
    endtask

    task automatic test_reset_mid_mul();
        logic seen = 1'b0;
        issue(4'b0010, 32'd1, 32'd1);
        checks++; if (result !== 32'd2) begin errors++;
            $display("FAIL pre_reset_add got %0d want 2", result); end
        @(posedge clk); #1;
        alucontrol = 4'b1100; a = 32'h1234_5678; b = 32'h9ABC_DEF0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b1) begin errors++;
            $display("FAIL mid_mul_busy got %b want 1", busy); end
        reset = 1'b1; #1;
        checks++; if ({busy, out_valid, in_ready} !== 3'b000 || result !== 32'h0) begin errors++;
            $display("FAIL mid_reset got %b r%h want 000 r0", {busy, out_valid, in_ready}, result); end
        @(posedge clk); #1;
        reset = 1'b0; #1;
        checks++; if (in_ready !== 1'b1) begin errors++;
            $display("FAIL mid_release_in_ready got %b want 1", in_ready); end
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid || busy) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++;
            $display("FAIL mid_reset_discard got %b want 0", seen); end
    endtask

    task automatic test_width8();
        issue8(4'b0101, 8'd3, 8'h80);
        checks++; if (result8 !== 8'h10 || lat != 1) begin errors++;
            $display("FAIL w8_srl got %h lat %0d want 10 lat 1", result8, lat); end
        issue8(4'b0100, 8'h00, 8'h0F);
        checks++; if (result8 !== 8'hF0) begin errors++;
            $display("FAIL w8_sllh got %h want f0", result8); end
        issue8(4'b1100, 8'hFF, 8'hFF);
        checks++; if (result8 !== 8'h01 || lat != 9) begin errors++;
            $display("FAIL w8_mul got %h lat %0d want 01 lat 9", result8, lat); end
        issue8(4'b1101, 8'hFF, 8'hFF);
        checks++; if (result8 !== 8'hFE || lat != 9) begin errors++;
            $display("FAIL w8_mulhu got %h lat %0d want fe lat 9", result8, lat); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_sub();
        test_single();
        test_mul();
        test_div();
        test_back_to_back();
        test_reset_mid_mul();
        test_width8();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_alu.md
MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width; legal values are even numbers 8..64.
REQ-002 SHALL have parameter SHW, default $clog2(WIDTH), shift-amount width taken from a[SHW-1:0].
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1, operands and opcode present.
REQ-006 SHALL have port in_ready, output, 1, operation accepted when in_valid && in_ready.
REQ-007 SHALL have ports a and b, input, WIDTH, operands.
REQ-008 SHALL have port alucontrol, input, 4, opcode.
REQ-009 SHALL have port out_valid, output, 1, result is valid.
REQ-010 SHALL have port out_ready, input, 1, consumer takes the result when out_valid && out_ready.
REQ-011 SHALL have port result, output, WIDTH, registered result.
REQ-012 SHALL have port zero, output, 1, registered (result == 0).
REQ-013 SHALL have port busy, output, 1, high while an iterative operation runs.

Function
REQ-014 SHALL implement these opcodes. 0000 a&b; 0001 a|b; 0010 a+b; 0110 a-b; 0111 unsigned a<b zero-extended; 0011 a^b; 0100 b<<(WIDTH/2); 0101 b>>a[SHW-1:0]; 1000 (a==0); 1001 zero-extended b[WIDTH/2-1:0]; 1010 result[W-1]=a[W-1], result[i]=a[i]^a[i+1].
REQ-015 SHALL implement these iterative opcodes, all unsigned. 1100 MUL: low WIDTH bits of a*b. 1101 MULHU: high WIDTH bits of a*b. 1110 DIVU: a/b. 1111 REMU: a%b.
REQ-016 SHALL return 0 for opcode 1011.
REQ-017 SHALL, for divide by zero, return all-ones for DIVU and a for REMU; no error is flagged.
REQ-018 SHALL use a state machine IDLE -> (single-cycle op) DONE, IDLE -> (iterative op) BUSY -> DONE; DONE -> IDLE on out_ready with no new accept; DONE -> DONE/BUSY on out_ready with a simultaneous accept.
REQ-019 SHALL drive in_ready = (state==IDLE) || (state==DONE && out_ready).
REQ-020 SHALL give single-cycle ops a latency of 1: accept in cycle N -> out_valid in cycle N+1.
REQ-021 SHALL give iterative ops a latency of WIDTH+1: one iteration per cycle, shift-add multiply, restoring divide.
REQ-022 SHALL hold result, zero and out_valid stable while out_valid && !out_ready (backpressure).
REQ-023 SHALL capture operands at accept; input changes after accept do not affect the result.
REQ-024 SHALL compute ADD/SUB modulo 2^WIDTH and discard carry-out.
REQ-025 SHALL keep busy=1 exactly in state BUSY.

Reset
REQ-026 SHALL, while reset=1 and regardless of clock, force state=IDLE, out_valid=0, result=0, zero=0 (reset value), busy=0, in_ready=0.
REQ-027 SHALL, on reset during BUSY or DONE, discard the operation with no output produced.
REQ-028 SHALL assert in_ready=1 in the first clock after reset deasserts.

Configuration
REQ-029 SHALL, with macro MULTICYCLE_ALU_DIV_EN defined, implement DIVU/REMU as in REQ-015 and REQ-017.
REQ-030 SHALL, without MULTICYCLE_ALU_DIV_EN, build no divider hardware; 1110/1111 then complete as single-cycle ops with result 0 and zero=1; MUL/MULHU are unaffected.

Structure
REQ-031 SHALL place the opcode enum (alu_op_t, 4-bit) and the state enum (alu_state_t) in package alu_pkg.
REQ-032 SHALL implement the iteration datapath (counter, partial product/remainder, quotient) in sub-module iter_muldiv with start/done handshake; the top holds the FSM and single-cycle logic.

Verification
REQ-033 SHALL cover: WIDTH=32, a=5, b=7, op 0110 -> result=0xFFFFFFFE, zero=0, out_valid 1 cycle after accept.
REQ-034 SHALL cover: a=0xFFFFFFFF, b=0xFFFFFFFF, op 1100 then 1101 -> 0x00000001 then 0xFFFFFFFE, each with 33-cycle latency and busy high 32 cycles.
REQ-035 SHALL cover: a=100, b=7, op 1110/1111 -> 14/2; with b=0 -> 0xFFFFFFFF/100; with the macro undefined -> 0 and zero=1.
REQ-036 SHALL cover: out_ready=0 for 5 cycles after an op-0010 result -> result held, in_ready=0; then out_ready=1 with in_valid=1 -> back-to-back accept in the same cycle.
REQ-037 SHALL cover: reset pulsed mid-MUL at iteration 10 -> out_valid never rises for that op; in_ready=1 the cycle after release.
REQ-038 SHALL cover: WIDTH=8, a=3, b=0x80, op 0101 -> 0x10; op 0100 with b=0x0F -> 0xF0.
